// File: rtl/victim_cache_controller.sv
// victim_cache_controller: sequences insert/extract/swap, replacement, writeback, flush and kill for a victim cache
//   clk, rst_n            : clock, asynchronous active-low reset
//   hit_vec_i             : raw tag match; victim_hit_o/hit_idx_o give the valid-qualified hit
//   insert_*, extract_*   : dcache handshakes; entry_wr_o/entry_idx_o steer the datapath
//   vc2mem_*, mem2vc_ack_i: dirty-line writeback to data memory
//   flush_i/flush_done_o  : write back and invalidate everything; kill_i aborts any operation
//   valid_o               : per-entry valid bits
module victim_cache_controller #(
  parameter int NUM_ENTRIES = 4,
  parameter int IDX_W = $clog2(NUM_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_ENTRIES-1:0] hit_vec_i,
  output logic                   victim_hit_o,
  output logic [IDX_W-1:0]       hit_idx_o,
  input  logic                   insert_req_i,
  input  logic                   insert_dirty_i,
  output logic                   insert_ack_o,
  input  logic                   extract_req_i,
  output logic                   extract_ack_o,
  output logic                   entry_wr_o,
  output logic [IDX_W-1:0]       entry_idx_o,
  output logic                   vc2mem_req_o,
  output logic                   vc2mem_wr_o,
  input  logic                   mem2vc_ack_i,
  output logic                   vc2mem_kill_o,
  input  logic                   flush_i,
  output logic                   flush_done_o,
  input  logic                   kill_i,
  output logic [NUM_ENTRIES-1:0] valid_o
);
  typedef enum logic [2:0] {
    VC_IDLE, VC_SWAP, VC_EXTRACT, VC_WB, VC_INSERT, VC_FLUSH_SCAN, VC_FLUSH_WB, VC_FLUSH_DONE
  } state_t;
  state_t state, state_nx;
  logic [NUM_ENTRIES-1:0] valid, dirty, hit_q;
  logic [IDX_W-1:0] fifo_ptr, target_ff, scan_idx, free_idx, ins_tgt;
  logic dirty_in_ff, fifo_sel_ff, any_free, ext_go, last_scan, scan_dirty;
  assign hit_q = hit_vec_i & valid;
  assign victim_hit_o = |hit_q;
  assign valid_o = valid;
  assign any_free = ~&valid;
  assign ins_tgt = any_free ? free_idx : fifo_ptr;
  assign ext_go = extract_req_i & victim_hit_o;
  assign last_scan = scan_idx == IDX_W'(NUM_ENTRIES - 1);
  assign scan_dirty = valid[scan_idx] & dirty[scan_idx];
  // Lowest index wins for both encoders; the hit vector is one-hot in normal use.
  always_comb begin
    hit_idx_o = '0;
    free_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (hit_q[i]) hit_idx_o = IDX_W'(i);
      if (!valid[i]) free_idx = IDX_W'(i);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= VC_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    insert_ack_o = 1'b0;
    extract_ack_o = 1'b0;
    entry_wr_o = 1'b0;
    entry_idx_o = '0;
    vc2mem_req_o = 1'b0;
    vc2mem_wr_o = 1'b0;
    vc2mem_kill_o = 1'b0;
    flush_done_o = 1'b0;
    case (state)
      VC_IDLE: state_nx = flush_i ? VC_FLUSH_SCAN :
                          (ext_go && insert_req_i) ? VC_SWAP :
                          ext_go ? VC_EXTRACT :
                          !insert_req_i ? VC_IDLE :
                          (valid[ins_tgt] && dirty[ins_tgt]) ? VC_WB : VC_INSERT;
      VC_SWAP: begin
        entry_wr_o = 1'b1;
        entry_idx_o = target_ff;
        insert_ack_o = 1'b1;
        extract_ack_o = 1'b1;
        state_nx = VC_IDLE;
      end
      VC_EXTRACT: begin
        entry_idx_o = target_ff;
        extract_ack_o = 1'b1;
        state_nx = VC_IDLE;
      end
      VC_WB: begin
        vc2mem_req_o = 1'b1;
        vc2mem_wr_o = 1'b1;
        entry_idx_o = target_ff;
        state_nx = mem2vc_ack_i ? VC_INSERT : VC_WB;
      end
      VC_INSERT: begin
        entry_wr_o = 1'b1;
        entry_idx_o = target_ff;
        insert_ack_o = 1'b1;
        state_nx = VC_IDLE;
      end
      VC_FLUSH_SCAN: begin
        entry_idx_o = scan_idx;
        state_nx = scan_dirty ? VC_FLUSH_WB : last_scan ? VC_FLUSH_DONE : VC_FLUSH_SCAN;
      end
      VC_FLUSH_WB: begin
        vc2mem_req_o = 1'b1;
        vc2mem_wr_o = 1'b1;
        entry_idx_o = scan_idx;
        state_nx = !mem2vc_ack_i ? VC_FLUSH_WB : last_scan ? VC_FLUSH_DONE : VC_FLUSH_SCAN;
      end
      VC_FLUSH_DONE: begin
        flush_done_o = 1'b1;
        state_nx = VC_IDLE;
      end
      default: state_nx = VC_IDLE;
    endcase
    if (kill_i) begin
      state_nx = VC_IDLE;
      insert_ack_o = 1'b0;
      extract_ack_o = 1'b0;
      entry_wr_o = 1'b0;
      vc2mem_req_o = 1'b0;
      vc2mem_wr_o = 1'b0;
      flush_done_o = 1'b0;
      vc2mem_kill_o = 1'b1;
    end
  end
  // target_ff holds the hit index for swap/extract and the replacement target for insert;
  // fifo_sel_ff remembers whether that target came from the round-robin pointer.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid <= '0;
      dirty <= '0;
      fifo_ptr <= '0;
      target_ff <= '0;
      dirty_in_ff <= 1'b0;
      fifo_sel_ff <= 1'b0;
      scan_idx <= '0;
    end else if (kill_i) begin
      scan_idx <= '0;
    end else begin
      case (state)
        VC_IDLE:
          if (!flush_i && (ext_go || insert_req_i)) begin
            target_ff <= ext_go ? hit_idx_o : ins_tgt;
            dirty_in_ff <= insert_dirty_i;
            fifo_sel_ff <= !ext_go && !any_free;
          end
        VC_SWAP: dirty[target_ff] <= dirty_in_ff;
        VC_EXTRACT: begin
          valid[target_ff] <= 1'b0;
          dirty[target_ff] <= 1'b0;
        end
        VC_WB: if (mem2vc_ack_i) dirty[target_ff] <= 1'b0;
        VC_INSERT: begin
          valid[target_ff] <= 1'b1;
          dirty[target_ff] <= dirty_in_ff;
          if (fifo_sel_ff) fifo_ptr <= fifo_ptr + IDX_W'(1);
        end
        VC_FLUSH_SCAN:
          if (!scan_dirty) begin
            valid[scan_idx] <= 1'b0;
            scan_idx <= scan_idx + IDX_W'(1);
          end
        VC_FLUSH_WB:
          if (mem2vc_ack_i) begin
            valid[scan_idx] <= 1'b0;
            dirty[scan_idx] <= 1'b0;
            scan_idx <= scan_idx + IDX_W'(1);
          end
        VC_FLUSH_DONE: begin
          scan_idx <= '0;
          fifo_ptr <= '0;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_victim_cache_controller.sv
// tb_victim_cache_controller: directed scoreboard bench for victim_cache_controller
module tb_victim_cache_controller;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] hit_vec_i = '0;
  logic insert_req_i = 1'b0, insert_dirty_i = 1'b0, extract_req_i = 1'b0;
  logic mem2vc_ack_i = 1'b0, flush_i = 1'b0, kill_i = 1'b0;
  logic victim_hit_o, insert_ack_o, extract_ack_o, entry_wr_o;
  logic vc2mem_req_o, vc2mem_wr_o, vc2mem_kill_o, flush_done_o;
  logic [1:0] hit_idx_o, entry_idx_o;
  logic [3:0] valid_o;
  int checks = 0, failures = 0, wb_seen = 0;
  int wr_q[$], wb_q[$];
  victim_cache_controller #(.NUM_ENTRIES(4)) dut (
    .clk(clk), .rst_n(rst_n), .hit_vec_i(hit_vec_i), .victim_hit_o(victim_hit_o),
    .hit_idx_o(hit_idx_o), .insert_req_i(insert_req_i), .insert_dirty_i(insert_dirty_i),
    .insert_ack_o(insert_ack_o), .extract_req_i(extract_req_i), .extract_ack_o(extract_ack_o),
    .entry_wr_o(entry_wr_o), .entry_idx_o(entry_idx_o), .vc2mem_req_o(vc2mem_req_o),
    .vc2mem_wr_o(vc2mem_wr_o), .mem2vc_ack_i(mem2vc_ack_i), .vc2mem_kill_o(vc2mem_kill_o),
    .flush_i(flush_i), .flush_done_o(flush_done_o), .kill_i(kill_i), .valid_o(valid_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Scoreboard: every datapath write and every acknowledged writeback must match the next queued index.
  always @(negedge clk)
    if (rst_n) begin
      if (entry_wr_o) begin
        if (wr_q.size() == 0) chk("unexpected_entry_wr", {30'd0, entry_idx_o}, 32'hdead);
        else chk("entry_wr_idx", {30'd0, entry_idx_o}, wr_q.pop_front());
      end
      if (vc2mem_req_o && mem2vc_ack_i) begin
        wb_seen++;
        chk("wb_wr", vc2mem_wr_o, 1);
        if (wb_q.size() == 0) chk("unexpected_wb", {30'd0, entry_idx_o}, 32'hdead);
        else chk("wb_idx", {30'd0, entry_idx_o}, wb_q.pop_front());
      end
    end
  task automatic ins(input logic d, input int idx);
    wr_q.push_back(idx);
    insert_req_i = 1'b1;
    insert_dirty_i = d;
    @(posedge clk);
    @(negedge clk);
    chk("ins_ack", insert_ack_o, 1);
    chk("ins_no_mem", vc2mem_req_o, 0);
    @(posedge clk); #1;
    insert_req_i = 1'b0;
  endtask
  task automatic ins_wb(input int idx, input int dly);
    wr_q.push_back(idx);
    wb_q.push_back(idx);
    insert_req_i = 1'b1;
    insert_dirty_i = 1'b0;
    @(posedge clk);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk("wb_req_held", {vc2mem_req_o, vc2mem_wr_o, insert_ack_o}, 3'b110);
      chk("wb_idx_held", {30'd0, entry_idx_o}, idx);
    end
    @(posedge clk); #1;
    mem2vc_ack_i = 1'b1;
    @(posedge clk); #1;
    mem2vc_ack_i = 1'b0;
    chk("wb_req_drop", vc2mem_req_o, 0);
    @(negedge clk);
    chk("wb_ins_ack", insert_ack_o, 1);
    @(posedge clk); #1;
    insert_req_i = 1'b0;
  endtask
  task automatic swap(input logic [3:0] hv, input logic d, input int idx);
    logic [3:0] v0;
    v0 = valid_o;
    wr_q.push_back(idx);
    hit_vec_i = hv;
    insert_req_i = 1'b1;
    insert_dirty_i = d;
    extract_req_i = 1'b1;
    #1;
    chk("swap_hit", {victim_hit_o, hit_idx_o}, {1'b1, 2'(idx)});
    @(posedge clk);
    @(negedge clk);
    chk("swap_acks", {insert_ack_o, extract_ack_o, entry_wr_o}, 3'b111);
    chk("swap_idx", {30'd0, entry_idx_o}, idx);
    @(posedge clk); #1;
    chk("swap_valid", valid_o, v0);
    {insert_req_i, extract_req_i, hit_vec_i} = '0;
  endtask
  initial begin
    bit done;
    int nd, wb0;
    #2;
    chk("rst_outs", {victim_hit_o, hit_idx_o, insert_ack_o, extract_ack_o, entry_wr_o, entry_idx_o,
                     vc2mem_req_o, vc2mem_wr_o, vc2mem_kill_o, flush_done_o, valid_o}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) ins(1'b0, k);
    chk("full_valid", valid_o, 4'b1111);
    swap(4'b0001, 1'b1, 0);
    ins_wb(0, 3);
    ins(1'b0, 1);
    swap(4'b0100, 1'b0, 2);
    hit_vec_i = 4'b0100;
    extract_req_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ext_acks", {insert_ack_o, extract_ack_o, entry_wr_o}, 3'b010);
    chk("ext_idx", {30'd0, entry_idx_o}, 2);
    @(posedge clk); #1;
    extract_req_i = 1'b0;
    chk("ext_valid", valid_o, 4'b1011);
    extract_req_i = 1'b1;
    #1;
    chk("miss_hit", {victim_hit_o, hit_idx_o}, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("miss_no_ack", {extract_ack_o, insert_ack_o, entry_wr_o}, 0);
    end
    @(posedge clk); #1;
    {extract_req_i, hit_vec_i} = '0;
    ins(1'b0, 2);
    swap(4'b0010, 1'b1, 1);
    swap(4'b1000, 1'b1, 3);
    wb_q.push_back(1);
    wb_q.push_back(3);
    wb0 = wb_seen;
    flush_i = 1'b1;
    done = 0;
    nd = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (flush_done_o) begin nd++; done = 1; end
      @(posedge clk); #1;
      mem2vc_ack_i = vc2mem_req_o;
    end
    flush_i = 1'b0;
    mem2vc_ack_i = 1'b0;
    @(negedge clk);
    chk("flush_done_seen", {31'd0, done}, 1);
    chk("flush_done_once", {31'd0, flush_done_o}, 0);
    chk("flush_wb_count", wb_seen - wb0, 2);
    chk("flush_valid", valid_o, 0);
    @(posedge clk); #1;
    ins(1'b1, 0);
    for (int k = 1; k < 4; k++) ins(1'b0, k);
    insert_req_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("kill_pre_req", vc2mem_req_o, 1);
    @(posedge clk); #1;
    kill_i = 1'b1;
    insert_req_i = 1'b0;
    #1;
    chk("kill_outs", {vc2mem_kill_o, vc2mem_req_o, entry_wr_o, insert_ack_o}, 4'b1000);
    @(posedge clk); #1;
    kill_i = 1'b0;
    @(negedge clk);
    chk("kill_idle", {vc2mem_kill_o, vc2mem_req_o, insert_ack_o}, 0);
    @(posedge clk); #1;
    ins_wb(0, 1);
    swap(4'b0001, 1'b1, 0);
    flush_i = 1'b1;
    @(posedge clk);
    @(posedge clk); #2;
    chk("rst_pre_req", vc2mem_req_o, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_outs", {victim_hit_o, hit_idx_o, insert_ack_o, extract_ack_o, entry_wr_o, entry_idx_o,
                           vc2mem_req_o, vc2mem_wr_o, vc2mem_kill_o, flush_done_o, valid_o}, 0);
    flush_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    ins(1'b0, 0);
    chk("wr_q_empty", wr_q.size(), 0);
    chk("wb_q_empty", wb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
